// File: rtl/vt52_pkg.sv
// Shared constants and state encoding for the VT52 command engine.
package vt52_pkg;

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] HT    = 8'h09;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;

  // Final bytes of two-byte escape sequences
  localparam logic [7:0] ESC_UP       = 8'h41;  // A
  localparam logic [7:0] ESC_DOWN     = 8'h42;  // B
  localparam logic [7:0] ESC_RIGHT    = 8'h43;  // C
  localparam logic [7:0] ESC_LEFT     = 8'h44;  // D
  localparam logic [7:0] ESC_HOME     = 8'h48;  // H
  localparam logic [7:0] ESC_RLF      = 8'h49;  // I
  localparam logic [7:0] ESC_EOS      = 8'h4A;  // J
  localparam logic [7:0] ESC_EOL      = 8'h4B;  // K
  localparam logic [7:0] ESC_ADDR     = 8'h59;  // Y
  localparam logic [7:0] ESC_WRAP_ON  = 8'h76;  // v
  localparam logic [7:0] ESC_WRAP_OFF = 8'h77;  // w

  typedef enum logic [2:0] {
    ST_CHAR  = 3'd0,
    ST_ESC   = 3'd1,
    ST_ROW   = 3'd2,
    ST_COL   = 3'd3,
    ST_ERASE = 3'd4
  } state_e;

endpackage

// File: rtl/vt52_erase_sequencer.sv
// Erase address walker: loads a start/last pair, steps by one (wrapping
// modulo the address space) and flags when the current address is the last.
module vt52_erase_sequencer
  import vt52_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              done
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;

  assign next_addr = addr_q + 1'b1;
  assign done      = (addr_q == last_q);

  always_comb begin
    addr_d = addr_q;
    last_d = last_q;
    if (start) begin
      addr_d = start_addr;
      last_d = last_addr;
    end else if (step) begin
      addr_d = next_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q <= '0;
      last_q <= '0;
    end else begin
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/vt52_command_engine.sv
// VT52 byte stream interpreter: cursor motion, scrolling, erase and
// character writes, all issued as one-phase pulses during px_clk-low cycles.
module vt52_command_engine
  import vt52_pkg::*;
#(
  parameter int COL_BITS     = 6,
  parameter int ROW_BITS     = 4,
  parameter bit WRAP_DEFAULT = 1'b0
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         px_clk,
  input  logic [7:0]                   data,
  input  logic                         valid,
  output logic                         ready,
  output logic [7:0]                   new_char,
  output logic [ROW_BITS+COL_BITS-1:0] new_char_address,
  output logic                         new_char_wen,
  output logic [COL_BITS-1:0]          new_cursor_x,
  output logic [ROW_BITS-1:0]          new_cursor_y,
  output logic                         new_cursor_wen,
  output logic [ROW_BITS-1:0]          new_first_row,
  output logic                         new_first_row_wen,
  output logic                         wrap_mode
);
  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int COLS   = 2**COL_BITS;
  localparam int ROWS   = 2**ROW_BITS;
  localparam logic [COL_BITS-1:0] X_MAX = '1;
  localparam logic [ROW_BITS-1:0] Y_MAX = '1;
  localparam logic [COL_BITS-1:0] X_MIN = '0;

  state_e              state_q, state_d;
  logic [COL_BITS-1:0] cursor_x_q, cursor_x_d;
  logic [ROW_BITS-1:0] cursor_y_q, cursor_y_d;
  logic [ROW_BITS-1:0] first_row_q, first_row_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                wrap_q, wrap_d;
  logic [7:0]          char_q, char_d;
  logic [ADDR_W-1:0]   char_addr_q, char_addr_d;
  logic                char_wen_q, char_wen_d;
  logic                cursor_wen_q, cursor_wen_d;
  logic                first_row_wen_q, first_row_wen_d;

  logic [ROW_BITS-1:0] phys_y, fr_prev;
  logic [7:0]          arg;
  logic                lf, put_char, erase_go;
  logic [ADDR_W-1:0]   erase_first, erase_last;
  logic                seq_start, seq_step, seq_done;
  logic [ADDR_W-1:0]   seq_start_addr, seq_next;

  assign phys_y  = cursor_y_q + first_row_q;
  assign fr_prev = first_row_q - 1'b1;
  assign arg     = data - SPACE;
  assign ready   = ~px_clk && (state_q != ST_ERASE);

  vt52_erase_sequencer #(.ADDR_W(ADDR_W)) u_erase (
    .clk        (clk),
    .clr        (clr),
    .start      (seq_start),
    .step       (seq_step),
    .start_addr (seq_start_addr),
    .last_addr  (erase_last),
    .next_addr  (seq_next),
    .done       (seq_done)
  );

  always_comb begin
    state_d     = state_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    first_row_d = first_row_q;
    row_d       = row_q;
    wrap_d      = wrap_q;
    char_d      = char_q;
    char_addr_d = char_addr_q;
    char_wen_d  = 1'b0;
    lf          = 1'b0;
    put_char    = 1'b0;
    erase_go    = 1'b0;
    erase_first = '0;
    erase_last  = '0;
    seq_start   = 1'b0;
    seq_step    = 1'b0;
    seq_start_addr = '0;
    if (!px_clk) begin
      if (state_q == ST_ERASE) begin
        if (seq_done) state_d = ST_CHAR;
        else begin
          seq_step    = 1'b1;
          char_d      = SPACE;
          char_addr_d = seq_next;
          char_wen_d  = 1'b1;
        end
      end else if (valid) begin
        case (state_q)
          ST_CHAR: begin
            if (data >= SPACE && data <= TILDE) begin
              put_char = 1'b1;
              if (cursor_x_q != X_MAX) cursor_x_d = cursor_x_q + 1'b1;
              else if (wrap_q) begin
                cursor_x_d = X_MIN;
                lf         = 1'b1;
              end
            end else begin
              case (data)
                BS: if (cursor_x_q != X_MIN) cursor_x_d = cursor_x_q - 1'b1;
                HT: begin
                  if (int'(cursor_x_q) < COLS - 8)
                    cursor_x_d = (cursor_x_q | COL_BITS'(7)) + 1'b1;
                  else if (cursor_x_q != X_MAX)
                    cursor_x_d = cursor_x_q + 1'b1;
                end
                LF:  lf = 1'b1;
                CR:  cursor_x_d = X_MIN;
                ESC: state_d = ST_ESC;
                default: ;
              endcase
            end
          end
          ST_ESC: begin
            state_d = ST_CHAR;
            case (data)
              ESC_UP:    if (cursor_y_q != '0) cursor_y_d = cursor_y_q - 1'b1;
              ESC_DOWN:  if (cursor_y_q != Y_MAX) cursor_y_d = cursor_y_q + 1'b1;
              ESC_RIGHT: if (cursor_x_q != X_MAX) cursor_x_d = cursor_x_q + 1'b1;
              ESC_LEFT:  if (cursor_x_q != X_MIN) cursor_x_d = cursor_x_q - 1'b1;
              ESC_HOME: begin
                cursor_x_d = X_MIN;
                cursor_y_d = '0;
              end
              ESC_RLF: begin
                if (cursor_y_q != '0) cursor_y_d = cursor_y_q - 1'b1;
                else begin
                  first_row_d = fr_prev;
                  erase_go    = 1'b1;
                  erase_first = {fr_prev, X_MIN};
                  erase_last  = {fr_prev, X_MAX};
                end
              end
              ESC_EOL: begin
                erase_go    = 1'b1;
                erase_first = {phys_y, cursor_x_q};
                erase_last  = {phys_y, X_MAX};
              end
              ESC_EOS: begin
                erase_go    = 1'b1;
                erase_first = {phys_y, cursor_x_q};
                erase_last  = {fr_prev, X_MAX};
              end
              ESC_WRAP_ON:  wrap_d  = 1'b1;
              ESC_WRAP_OFF: wrap_d  = 1'b0;
              ESC_ADDR:     state_d = ST_ROW;
              ESC:          state_d = ST_ESC;
              default: ;
            endcase
          end
          ST_ROW: begin
            row_d   = (int'(arg) < ROWS) ? arg[ROW_BITS-1:0] : cursor_y_q;
            state_d = ST_COL;
          end
          ST_COL: begin
            cursor_x_d = (int'(arg) < COLS) ? arg[COL_BITS-1:0] : X_MAX;
            cursor_y_d = row_q;
            state_d    = ST_CHAR;
          end
          default: state_d = ST_CHAR;
        endcase

        if (lf) begin
          if (cursor_y_q != Y_MAX) cursor_y_d = cursor_y_q + 1'b1;
          else begin
            first_row_d = first_row_q + 1'b1;
            erase_go    = 1'b1;
            erase_first = {first_row_q, X_MIN};
            erase_last  = {first_row_q, X_MAX};
          end
        end

        // A wrapping char that also scrolls owns the write port this cycle,
        // so the walker is preloaded one address early and the erase starts
        // on the next low phase.
        if (erase_go) begin
          state_d        = ST_ERASE;
          seq_start      = 1'b1;
          seq_start_addr = put_char ? erase_first - 1'b1 : erase_first;
        end
        if (put_char) begin
          char_d      = data;
          char_addr_d = {phys_y, cursor_x_q};
          char_wen_d  = 1'b1;
        end else if (erase_go) begin
          char_d      = SPACE;
          char_addr_d = erase_first;
          char_wen_d  = 1'b1;
        end
      end
    end
    cursor_wen_d    = (cursor_x_d != cursor_x_q) || (cursor_y_d != cursor_y_q);
    first_row_wen_d = (first_row_d != first_row_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= ST_CHAR;
      cursor_x_q      <= '0;
      cursor_y_q      <= '0;
      first_row_q     <= '0;
      row_q           <= '0;
      wrap_q          <= WRAP_DEFAULT;
      char_q          <= '0;
      char_addr_q     <= '0;
      char_wen_q      <= 1'b0;
      cursor_wen_q    <= 1'b0;
      first_row_wen_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cursor_x_q      <= cursor_x_d;
      cursor_y_q      <= cursor_y_d;
      first_row_q     <= first_row_d;
      row_q           <= row_d;
      wrap_q          <= wrap_d;
      char_q          <= char_d;
      char_addr_q     <= char_addr_d;
      char_wen_q      <= char_wen_d;
      cursor_wen_q    <= cursor_wen_d;
      first_row_wen_q <= first_row_wen_d;
    end
  end

  assign new_char          = char_q;
  assign new_char_address  = char_addr_q;
  assign new_char_wen      = char_wen_q;
  assign new_cursor_x      = cursor_x_q;
  assign new_cursor_y      = cursor_y_q;
  assign new_cursor_wen    = cursor_wen_q;
  assign new_first_row     = first_row_q;
  assign new_first_row_wen = first_row_wen_q;
  assign wrap_mode         = wrap_q;
endmodule

// File: tb/tb_vt52_command_engine.sv
// Bench for vt52_command_engine: vector table, corner sequences and random
// bytes, all checked against a screen-level reference model.
module tb_vt52_command_engine;
  localparam int COLS  = 64;
  localparam int ROWS  = 16;
  localparam int NADDR = COLS * ROWS;

  logic       clk = 1'b0;
  logic       clr, px_clk, valid;
  logic [7:0] data;
  logic       ready, new_char_wen, new_cursor_wen, new_first_row_wen, wrap_mode;
  logic [7:0] new_char;
  logic [9:0] new_char_address;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y, new_first_row;

  vt52_command_engine dut (
    .clk(clk), .clr(clr), .px_clk(px_clk), .data(data), .valid(valid), .ready(ready),
    .new_char(new_char), .new_char_address(new_char_address), .new_char_wen(new_char_wen),
    .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y), .new_cursor_wen(new_cursor_wen),
    .new_first_row(new_first_row), .new_first_row_wen(new_first_row_wen), .wrap_mode(wrap_mode)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: screen-level terminal state plus a queue of pending erase addresses
  int m_x, m_y, m_fr, m_wrap, m_mode, m_row;
  bit m_erasing;
  int eq[$];
  int e_cw, e_ch, e_ca, e_curw, e_frw;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_x = 0; m_y = 0; m_fr = 0; m_wrap = 0; m_mode = 0; m_row = 0;
    m_erasing = 0; eq.delete();
    e_cw = 0; e_ch = 0; e_ca = 0; e_curw = 0; e_frw = 0;
  endtask

  task automatic put(input int c, input int a);
    e_cw = 1; e_ch = c; e_ca = a;
  endtask

  task automatic m_erase(input int first, input int last, input bit char_now);
    int a;
    a = first;
    eq.delete();
    while (1) begin
      eq.push_back(a);
      if (a == last) break;
      a = (a + 1) % NADDR;
    end
    if (!char_now) put(32, eq.pop_front());
    m_erasing = 1;
  endtask

  task automatic m_lf(input bit char_now);
    int old;
    if (m_y < ROWS - 1) m_y++;
    else begin
      old  = m_fr;
      m_fr = (m_fr + 1) % ROWS;
      m_erase(old * COLS, old * COLS + COLS - 1, char_now);
    end
  endtask

  task automatic m_accept(input int d);
    int p;
    p = (m_y + m_fr) % ROWS;
    case (m_mode)
      0: begin
        if (d >= 32 && d <= 126) begin
          put(d, p * COLS + m_x);
          if (m_x < COLS - 1) m_x++;
          else if (m_wrap != 0) begin m_x = 0; m_lf(1); end
        end else begin
          case (d)
            8:  if (m_x > 0) m_x--;
            9:  if (m_x < COLS - 8) m_x = (m_x / 8 + 1) * 8;
                else if (m_x < COLS - 1) m_x++;
            10: m_lf(0);
            13: m_x = 0;
            27: m_mode = 1;
            default: ;
          endcase
        end
      end
      1: begin
        m_mode = 0;
        case (d)
          8'h41: if (m_y > 0) m_y--;
          8'h42: if (m_y < ROWS - 1) m_y++;
          8'h43: if (m_x < COLS - 1) m_x++;
          8'h44: if (m_x > 0) m_x--;
          8'h48: begin m_x = 0; m_y = 0; end
          8'h49: if (m_y > 0) m_y--;
                 else begin
                   m_fr = (m_fr + ROWS - 1) % ROWS;
                   m_erase(m_fr * COLS, m_fr * COLS + COLS - 1, 0);
                 end
          8'h4B: m_erase(p * COLS + m_x, p * COLS + COLS - 1, 0);
          8'h4A: m_erase(p * COLS + m_x, ((m_fr + ROWS - 1) % ROWS) * COLS + COLS - 1, 0);
          8'h76: m_wrap = 1;
          8'h77: m_wrap = 0;
          8'h59: m_mode = 2;
          8'h1B: m_mode = 1;
          default: ;
        endcase
      end
      2: begin
        m_row  = (d >= 32 && d - 32 < ROWS) ? d - 32 : m_y;
        m_mode = 3;
      end
      default: begin
        m_x    = (d >= 32 && d - 32 < COLS) ? d - 32 : COLS - 1;
        m_y    = m_row;
        m_mode = 0;
      end
    endcase
  endtask

  // One clk cycle: drive, predict, clock, compare, advance the px phase
  task automatic step(input bit v, input int d, input bit c);
    int ox, oy, ofr;
    valid = v; data = d[7:0]; clr = c;
    #1;
    chk("ready", int'(ready), int'(!px_clk && !m_erasing));
    e_cw = 0; e_curw = 0; e_frw = 0;
    ox = m_x; oy = m_y; ofr = m_fr;
    if (c) m_reset();
    else if (!px_clk) begin
      if (m_erasing) begin
        if (eq.size() == 0) m_erasing = 0;
        else put(32, eq.pop_front());
      end else if (v) m_accept(d);
    end
    if (!c) begin
      e_curw = int'(m_x != ox || m_y != oy);
      e_frw  = int'(m_fr != ofr);
    end
    @(posedge clk); #1;
    chk("char_wen",    int'(new_char_wen), e_cw);
    chk("char",        int'(new_char), e_ch);
    chk("char_addr",   int'(new_char_address), e_ca);
    chk("cursor_x",    int'(new_cursor_x), m_x);
    chk("cursor_y",    int'(new_cursor_y), m_y);
    chk("cursor_wen",  int'(new_cursor_wen), e_curw);
    chk("first_row",   int'(new_first_row), m_fr);
    chk("fr_wen",      int'(new_first_row_wen), e_frw);
    chk("wrap_mode",   int'(wrap_mode), m_wrap);
    px_clk = ~px_clk;
    valid  = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic send(input int d);
    int n;
    n = 0;
    while ((px_clk || m_erasing) && n < 3000) begin step(0, 0, 0); n++; end
    if (n >= 3000) chk("send_timeout", n, 0);
    step(1, d, 0);
  endtask

  task automatic esc(input int f);
    send(27); send(f);
  endtask

  task automatic goto_rc(input int r, input int c);
    send(27); send(8'h59); send(r + 32); send(c + 32);
  endtask

  typedef struct { bit rst; int d; int ex; int ey; int ea; int ec; } tv_t;
  tv_t tv[$];
  int lets[11] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h59, 8'h76, 8'h77};
  int ctls[5]  = '{8, 9, 10, 13, 27};

  initial begin
    int lowcnt, writes, n, d;
    bit v;
    px_clk = 1'b0; clr = 1'b1; valid = 1'b0; data = 8'h00;
    m_reset();
    @(posedge clk); #1;
    px_clk = 1'b1; clr = 1'b0;

    // {rst, byte, expected x, expected y, expected write address (-1: none), char}
    tv.push_back('{1, 0,     0,  0, -1,  0});
    tv.push_back('{0, 8'h41, 1,  0,  0,  8'h41});
    tv.push_back('{0, 8'h42, 2,  0,  1,  8'h42});
    tv.push_back('{0, 27,    2,  0, -1,  0});
    tv.push_back('{0, 8'h59, 2,  0, -1,  0});
    tv.push_back('{0, 8'h25, 2,  0, -1,  0});
    tv.push_back('{0, 8'h30, 16, 5, -1,  0});
    tv.push_back('{0, 27,    16, 5, -1,  0});
    tv.push_back('{0, 8'h59, 16, 5, -1,  0});
    tv.push_back('{0, 8'h40, 16, 5, -1,  0});
    tv.push_back('{0, 8'h7F, 63, 5, -1,  0});
    tv.push_back('{0, 8,     62, 5, -1,  0});
    tv.push_back('{0, 9,     63, 5, -1,  0});
    tv.push_back('{0, 9,     63, 5, -1,  0});
    tv.push_back('{0, 13,    0,  5, -1,  0});
    tv.push_back('{0, 9,     8,  5, -1,  0});
    tv.push_back('{0, 9,     16, 5, -1,  0});
    tv.push_back('{0, 8'h5A, 17, 5, 336, 8'h5A});
    tv.push_back('{0, 27,    17, 5, -1,  0});
    tv.push_back('{0, 8'h41, 17, 4, -1,  0});
    tv.push_back('{0, 27,    17, 4, -1,  0});
    tv.push_back('{0, 8'h43, 18, 4, -1,  0});
    tv.push_back('{0, 27,    18, 4, -1,  0});
    tv.push_back('{0, 8'h48, 0,  0, -1,  0});
    tv.push_back('{0, 27,    0,  0, -1,  0});
    tv.push_back('{0, 8'h41, 0,  0, -1,  0});
    tv.push_back('{0, 8,     0,  0, -1,  0});
    tv.push_back('{0, 7,     0,  0, -1,  0});
    tv.push_back('{0, 27,    0,  0, -1,  0});
    tv.push_back('{0, 8'h51, 0,  0, -1,  0});
    tv.push_back('{0, 8'h61, 1,  0,  0,  8'h61});
    tv.push_back('{0, 27,    1,  0, -1,  0});
    tv.push_back('{0, 8'h59, 1,  0, -1,  0});
    tv.push_back('{0, 8'h1F, 1,  0, -1,  0});
    tv.push_back('{0, 8'h10, 63, 0, -1,  0});

    foreach (tv[i]) begin
      if (tv[i].rst) step(0, 0, 1);
      else send(tv[i].d);
      chk("tv_x", int'(new_cursor_x), tv[i].ex);
      chk("tv_y", int'(new_cursor_y), tv[i].ey);
      if (tv[i].ea >= 0) begin
        chk("tv_wen",  int'(new_char_wen), 1);
        chk("tv_addr", int'(new_char_address), tv[i].ea);
        chk("tv_char", int'(new_char), tv[i].ec);
      end
    end

    // Linefeed on the bottom row scrolls and erases the old top row
    step(0, 0, 1);
    goto_rc(15, 0);
    send(10);
    chk("lf_first_row", int'(new_first_row), 1);
    chk("lf_first_addr", int'(new_char_address), 0);
    lowcnt = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!px_clk) begin
        if (ready) break;
        lowcnt++;
      end
      step(0, 0, 0);
    end
    chk("lf_ready_low_cycles", lowcnt, 64);

    // Autowrap on, then off, at the right margin
    step(0, 0, 1);
    esc(8'h76);
    goto_rc(3, 62);
    send(8'h58);
    chk("wrap_x_addr", int'(new_char_address), 8'h0FE);
    send(8'h59);
    chk("wrap_y_addr", int'(new_char_address), 8'h0FF);
    chk("wrap_cx", int'(new_cursor_x), 0);
    chk("wrap_cy", int'(new_cursor_y), 4);
    esc(8'h77);
    goto_rc(3, 62);
    send(8'h58);
    send(8'h59);
    chk("nowrap_cx", int'(new_cursor_x), 63);
    chk("nowrap_cy", int'(new_cursor_y), 3);

    // Reverse linefeed at the top row scrolls back and erases row 15
    step(0, 0, 1);
    esc(8'h49);
    chk("rlf_first_row", int'(new_first_row), 15);
    chk("rlf_first_addr", int'(new_char_address), 10'h3C0);
    send(8'h20);

    // Erase to end of screen interrupted by clr
    step(0, 0, 1);
    goto_rc(2, 10);
    esc(8'h4A);
    writes = 1; n = 0;
    while (writes < 5 && n < 40) begin
      step(0, 0, 0);
      if (e_cw != 0) writes++;
      n++;
    end
    chk("eos_writes_before_clr", writes, 5);
    step(0, 0, 1);
    chk("clr_x", int'(new_cursor_x), 0);
    chk("clr_y", int'(new_cursor_y), 0);
    chk("clr_addr", int'(new_char_address), 0);
    chk("clr_wen", int'(new_char_wen), 0);
    if (px_clk) step(0, 0, 0);
    #1;
    chk("clr_ready", int'(ready), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // Random bytes against the model
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom % 4) != 0;
      case ($urandom % 8)
        0, 1, 2: d = $urandom_range(32, 126);
        3:       d = ctls[$urandom % 5];
        4:       d = 27;
        5:       d = lets[$urandom % 11];
        6:       d = $urandom % 256;
        default: d = $urandom_range(32, 96);
      endcase
      step(v, d, ($urandom % 1500) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
